med_dose_scheduler: RTL and testbench

Parametrised multi-channel dose scheduler for the medicine reminder. Each of `NUM_CH` channels holds a dosing period and a countdown, and raises a due flag when its countdown expires. It counts doses missed while a flag is still pending and accepts acknowledgements only while the passcode block reports unlocked. It replaces the single-medicine timer/RAM2 countdown path and drives the LED and 7-segment display logic in the top level.

---
 rtl/med_dose_scheduler.sv | 123 ++++++++++++
 tb/tb_med_dose_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/med_dose_scheduler.sv
// Multi-channel medicine dose scheduler: per-channel period countdown, due flags,
// saturating missed-dose counters and passcode-gated configuration/acknowledge.
module med_dose_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 4,
    parameter int MISS_W   = 3,
    parameter int TICK_DIV = 50_000_000,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              T_Mode,
    input  logic              Unlock,
    input  logic              Cfg_We,
    input  logic [CH_W-1:0]   Cfg_Ch,
    input  logic [CNT_W-1:0]  Cfg_Period,
    input  logic              Ack,
    input  logic [CH_W-1:0]   Ack_Ch,
    input  logic [CH_W-1:0]   Sel_Ch,
    output logic [NUM_CH-1:0] Due,
    output logic [NUM_CH-1:0] Active,
    output logic              Any_Due,
    output logic [CNT_W-1:0]  Sel_TimeRem,
    output logic [MISS_W-1:0] Sel_Miss,
    output logic              Ack_Reject
);

    localparam int PS_W = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0]   prescaler;
    logic              tick;
    logic [CNT_W-1:0]  period [NUM_CH];
    logic [CNT_W-1:0]  rem    [NUM_CH];
    logic [MISS_W-1:0] miss   [NUM_CH];
    logic [NUM_CH-1:0] due_q;
    logic [NUM_CH-1:0] active_q;
    logic              ack_reject_q;
    logic [NUM_CH-1:0] cfg_hit;
    logic [NUM_CH-1:0] ack_hit;

    // The prescaler free-runs even in test mode, so leaving test mode keeps its phase.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            prescaler <= '0;
        end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

    assign tick = T_Mode || (prescaler == PS_LAST);

    // Out-of-range channel numbers match no channel, so they are ignored or refused.
    always_comb begin
        cfg_hit = '0;
        ack_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = Cfg_We && Unlock && (Cfg_Ch == CH_W'(i));
            ack_hit[i] = Ack && Unlock && (Ack_Ch == CH_W'(i)) && due_q[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period[i] <= '0;
                rem[i]    <= '0;
                miss[i]   <= '0;
            end
            due_q        <= '0;
            active_q     <= '0;
            ack_reject_q <= 1'b0;
        end else begin
            ack_reject_q <= Ack && !(|ack_hit);
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_hit[i]) begin
                    period[i]   <= Cfg_Period;
                    rem[i]      <= Cfg_Period;
                    due_q[i]    <= 1'b0;
                    miss[i]     <= '0;
                    active_q[i] <= (Cfg_Period != '0);
                end else if (period[i] == '0) begin
                    rem[i]   <= '0;
                    due_q[i] <= 1'b0;
                    miss[i]  <= '0;
                end else if (tick && rem[i] <= CNT_W'(1)) begin
                    // An ack landing on the expiry tick retires the old dose, so it is not a miss.
                    rem[i]   <= period[i];
                    due_q[i] <= 1'b1;
                    if (due_q[i] && !ack_hit[i] && miss[i] != '1) begin
                        miss[i] <= miss[i] + MISS_W'(1);
                    end
                end else begin
                    if (tick) begin
                        rem[i] <= rem[i] - CNT_W'(1);
                    end
                    if (ack_hit[i]) begin
                        due_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        Sel_TimeRem = '0;
        Sel_Miss    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (Sel_Ch == CH_W'(i)) begin
                Sel_TimeRem = rem[i];
                Sel_Miss    = miss[i];
            end
        end
    end

    assign Due        = due_q;
    assign Active     = active_q;
    assign Any_Due    = |due_q;
    assign Ack_Reject = ack_reject_q;

endmodule

// File: tb/tb_med_dose_scheduler.sv
// Directed bench for med_dose_scheduler: expected snapshots are queued with each
// stimulus step and checked against the outputs one cycle later.
module tb_med_dose_scheduler;

    logic       Clk = 1'b0;
    logic       Rst, T_Mode, Unlock, Cfg_We, Ack;
    logic [1:0] Cfg_Ch, Ack_Ch, Sel_Ch;
    logic [3:0] Cfg_Period;
    logic [3:0] Due, Active, Sel_TimeRem;
    logic       Any_Due, Ack_Reject;
    logic [2:0] Sel_Miss;

    localparam logic [4:0] C_ALL = 5'b11111;

    typedef struct {
        string      tag;
        logic [4:0] care;
        logic [3:0] due;
        logic [3:0] act;
        logic [3:0] rem;
        logic [2:0] miss;
        logic       rej;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    med_dose_scheduler #(
        .NUM_CH(4), .CNT_W(4), .MISS_W(3), .TICK_DIV(4)
    ) dut (
        .Clk(Clk), .Rst(Rst), .T_Mode(T_Mode), .Unlock(Unlock),
        .Cfg_We(Cfg_We), .Cfg_Ch(Cfg_Ch), .Cfg_Period(Cfg_Period),
        .Ack(Ack), .Ack_Ch(Ack_Ch), .Sel_Ch(Sel_Ch),
        .Due(Due), .Active(Active), .Any_Due(Any_Due),
        .Sel_TimeRem(Sel_TimeRem), .Sel_Miss(Sel_Miss), .Ack_Reject(Ack_Reject)
    );

    always #5 Clk = ~Clk;

    task automatic check_field(input string tag, input string name,
                               input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, name, obs, exp);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        if (e.care[0]) begin
            check_field(e.tag, "due", Due, e.due);
            check_field(e.tag, "any_due", {3'b0, Any_Due}, {3'b0, |e.due});
        end
        if (e.care[1]) check_field(e.tag, "active", Active, e.act);
        if (e.care[2]) check_field(e.tag, "time_rem", Sel_TimeRem, e.rem);
        if (e.care[3]) check_field(e.tag, "miss", {1'b0, Sel_Miss}, {1'b0, e.miss});
        if (e.care[4]) check_field(e.tag, "ack_reject", {3'b0, Ack_Reject}, {3'b0, e.rej});
    endtask

    // One clock step: queue the expectation, let the edge happen, drop strobes, compare.
    task automatic apply_stimulus(input string tag, input logic [4:0] care,
                                  input logic [3:0] due, input logic [3:0] act,
                                  input logic [3:0] rem, input logic [2:0] miss,
                                  input logic rej);
        exp_t e;
        e.tag  = tag;
        e.care = care;
        e.due  = due;
        e.act  = act;
        e.rem  = rem;
        e.miss = miss;
        e.rej  = rej;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        Cfg_We = 1'b0;
        Ack    = 1'b0;
        check_output();
    endtask

    initial begin
        Rst = 1'b1; T_Mode = 1'b0; Unlock = 1'b0; Cfg_We = 1'b0; Ack = 1'b0;
        Cfg_Ch = 2'd0; Ack_Ch = 2'd0; Sel_Ch = 2'd2; Cfg_Period = 4'd0;

        apply_stimulus("reset_a", C_ALL, 4'h0, 4'h0, 4'd0, 3'd0, 1'b0);
        apply_stimulus("reset_b", C_ALL, 4'h0, 4'h0, 4'd0, 3'd0, 1'b0);
        Rst = 1'b0;
        for (int c = 0; c < 20; c++) apply_stimulus("idle", C_ALL, 4'h0, 4'h0, 4'd0, 3'd0, 1'b0);

        // Fast expiry of ch2 in test mode.
        T_Mode = 1'b1; Unlock = 1'b1; Sel_Ch = 2'd2;
        Cfg_We = 1'b1; Cfg_Ch = 2'd2; Cfg_Period = 4'd3;
        apply_stimulus("cfg_ch2", C_ALL, 4'b0000, 4'b0100, 4'd3, 3'd0, 1'b0);
        apply_stimulus("cnt_ch2_2", C_ALL, 4'b0000, 4'b0100, 4'd2, 3'd0, 1'b0);
        apply_stimulus("cnt_ch2_1", C_ALL, 4'b0000, 4'b0100, 4'd1, 3'd0, 1'b0);
        apply_stimulus("due_ch2", C_ALL, 4'b0100, 4'b0100, 4'd3, 3'd0, 1'b0);

        // Slow mode: reset aligns the prescaler so the write lands on a tick edge.
        T_Mode = 1'b0; Rst = 1'b1;
        apply_stimulus("reset_mid_count", C_ALL, 4'h0, 4'h0, 4'd0, 3'd0, 1'b0);
        Rst = 1'b0;
        for (int c = 0; c < 3; c++) apply_stimulus("slow_idle", C_ALL, 4'h0, 4'h0, 4'd0, 3'd0, 1'b0);
        Cfg_We = 1'b1; Cfg_Ch = 2'd2; Cfg_Period = 4'd3;
        apply_stimulus("cfg_slow", C_ALL, 4'b0000, 4'b0100, 4'd3, 3'd0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            if (c < 12) apply_stimulus("slow_cnt", C_ALL, 4'b0000, 4'b0100, 4'(3 - c / 4), 3'd0, 1'b0);
            else        apply_stimulus("slow_due", C_ALL, 4'b0100, 4'b0100, 4'd3, 3'd0, 1'b0);
        end

        // Missed-dose saturation on ch0 with period 1.
        Rst = 1'b1;
        apply_stimulus("reset_c", C_ALL, 4'h0, 4'h0, 4'd0, 3'd0, 1'b0);
        Rst = 1'b0; T_Mode = 1'b1; Sel_Ch = 2'd0;
        Cfg_We = 1'b1; Cfg_Ch = 2'd0; Cfg_Period = 4'd1;
        apply_stimulus("cfg_ch0", C_ALL, 4'b0000, 4'b0001, 4'd1, 3'd0, 1'b0);
        for (int c = 1; c <= 12; c++)
            apply_stimulus("miss_sat", C_ALL, 4'b0001, 4'b0001, 4'd1, (c - 1 > 7) ? 3'd7 : 3'(c - 1), 1'b0);

        // Acknowledge path on ch1 (ch0 stays permanently due).
        Sel_Ch = 2'd1;
        Cfg_We = 1'b1; Cfg_Ch = 2'd1; Cfg_Period = 4'd4;
        apply_stimulus("cfg_ch1", C_ALL, 4'b0001, 4'b0011, 4'd4, 3'd0, 1'b0);
        apply_stimulus("cnt_ch1_3", C_ALL, 4'b0001, 4'b0011, 4'd3, 3'd0, 1'b0);
        apply_stimulus("cnt_ch1_2", C_ALL, 4'b0001, 4'b0011, 4'd2, 3'd0, 1'b0);
        apply_stimulus("cnt_ch1_1", C_ALL, 4'b0001, 4'b0011, 4'd1, 3'd0, 1'b0);
        apply_stimulus("due_ch1", C_ALL, 4'b0011, 4'b0011, 4'd4, 3'd0, 1'b0);
        Unlock = 1'b0; Ack = 1'b1; Ack_Ch = 2'd1;
        apply_stimulus("ack_locked", C_ALL, 4'b0011, 4'b0011, 4'd3, 3'd0, 1'b1);
        Unlock = 1'b1; Ack = 1'b1; Ack_Ch = 2'd1;
        apply_stimulus("ack_ok", C_ALL, 4'b0001, 4'b0011, 4'd2, 3'd0, 1'b0);
        Ack = 1'b1; Ack_Ch = 2'd1;
        apply_stimulus("ack_again", C_ALL, 4'b0001, 4'b0011, 4'd1, 3'd0, 1'b1);
        apply_stimulus("redue_ch1", C_ALL, 4'b0011, 4'b0011, 4'd4, 3'd0, 1'b0);
        Cfg_We = 1'b1; Cfg_Ch = 2'd1; Cfg_Period = 4'd0;
        apply_stimulus("disable_ch1", C_ALL, 4'b0001, 4'b0001, 4'd0, 3'd0, 1'b0);
        Sel_Ch = 2'd0; Cfg_We = 1'b1; Cfg_Ch = 2'd0; Cfg_Period = 4'd0;
        apply_stimulus("disable_ch0", C_ALL, 4'b0000, 4'b0000, 4'd0, 3'd0, 1'b0);

        // Same-edge collisions on ch3.
        Sel_Ch = 2'd3;
        Cfg_We = 1'b1; Cfg_Ch = 2'd3; Cfg_Period = 4'd2;
        apply_stimulus("cfg_ch3", C_ALL, 4'b0000, 4'b1000, 4'd2, 3'd0, 1'b0);
        apply_stimulus("cnt_ch3_1", C_ALL, 4'b0000, 4'b1000, 4'd1, 3'd0, 1'b0);
        apply_stimulus("due_ch3", C_ALL, 4'b1000, 4'b1000, 4'd2, 3'd0, 1'b0);
        apply_stimulus("pend_ch3", C_ALL, 4'b1000, 4'b1000, 4'd1, 3'd0, 1'b0);
        apply_stimulus("miss_ch3", C_ALL, 4'b1000, 4'b1000, 4'd2, 3'd1, 1'b0);
        apply_stimulus("pend_ch3_b", C_ALL, 4'b1000, 4'b1000, 4'd1, 3'd1, 1'b0);
        Ack = 1'b1; Ack_Ch = 2'd3;
        apply_stimulus("ack_on_expiry", C_ALL, 4'b1000, 4'b1000, 4'd2, 3'd1, 1'b0);
        apply_stimulus("pend_ch3_c", C_ALL, 4'b1000, 4'b1000, 4'd1, 3'd1, 1'b0);
        Cfg_We = 1'b1; Cfg_Ch = 2'd3; Cfg_Period = 4'd5;
        apply_stimulus("cfg_on_expiry", C_ALL, 4'b0000, 4'b1000, 4'd5, 3'd0, 1'b0);
        Cfg_We = 1'b1; Cfg_Ch = 2'd3; Cfg_Period = 4'd3; Ack = 1'b1; Ack_Ch = 2'd3;
        apply_stimulus("cfg_and_ack", C_ALL, 4'b0000, 4'b1000, 4'd3, 3'd0, 1'b1);

        // Locked writes are ignored, then a reset mid-countdown clears everything.
        Unlock = 1'b0;
        Cfg_We = 1'b1; Cfg_Ch = 2'd3; Cfg_Period = 4'd9;
        apply_stimulus("cfg_locked", C_ALL, 4'b0000, 4'b1000, 4'd2, 3'd0, 1'b0);
        Cfg_We = 1'b1; Cfg_Ch = 2'd2; Cfg_Period = 4'd5;
        apply_stimulus("cfg_locked_ch2", C_ALL, 4'b0000, 4'b1000, 4'd1, 3'd0, 1'b0);
        apply_stimulus("due_ch3_after", C_ALL, 4'b1000, 4'b1000, 4'd3, 3'd0, 1'b0);
        Rst = 1'b1;
        apply_stimulus("reset_mid_run", C_ALL, 4'h0, 4'h0, 4'd0, 3'd0, 1'b0);
        Rst = 1'b0;
        apply_stimulus("post_reset", C_ALL, 4'h0, 4'h0, 4'd0, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
